// File: rtl/dual_port_memory_pipelined.sv
// True dual-port RAM with per-port write-commit and read-return latency pipelines.
// Supports byte-lane writes, selectable read-during-write behaviour and a write-write collision flag.

// Valid/data shift pipeline. A stage's data loads only when its valid does,
// so the last stage holds the most recent value between transfers.
module dpm_pipe #(
  parameter int W      = 8,
  parameter int STAGES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  generate
    if (STAGES == 0) begin : g_pass
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_stages
      logic [STAGES-1:0] v;
      logic [W-1:0]      d [STAGES];

      // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v <= '0;
          for (int i = 0; i < STAGES; i++) d[i] <= '0;
        end else begin
          v[0] <= in_valid;
          if (in_valid) d[0] <= in_data;
          for (int i = 1; i < STAGES; i++) begin
            v[i] <= v[i-1];
            if (v[i-1]) d[i] <= d[i-1];
          end
        end
      end

      assign out_valid = v[STAGES-1];
      assign out_data  = d[STAGES-1];
    end
  endgenerate
endmodule

module dual_port_memory_pipelined #(
  parameter int WIDTH           = 8,
  parameter int ADDR_WIDTH      = 3,
  parameter int DEPTH           = 2 ** ADDR_WIDTH,
  parameter int BYTE_W          = 8,
  parameter int WRITE_LATENCY_A = 4,
  parameter int READ_LATENCY_A  = 5,
  parameter int WRITE_LATENCY_B = 4,
  parameter int READ_LATENCY_B  = 5,
  parameter int RDW_MODE        = 0,
  parameter int WW_PRIORITY     = 0,
  localparam int NB             = WIDTH / BYTE_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en_a,
  input  logic [NB-1:0]         i_we_a,
  input  logic [ADDR_WIDTH-1:0] i_addr_a,
  input  logic [WIDTH-1:0]      i_din_a,
  output logic [WIDTH-1:0]      o_dout_a,
  output logic                  o_valid_a,
  input  logic                  i_en_b,
  input  logic [NB-1:0]         i_we_b,
  input  logic [ADDR_WIDTH-1:0] i_addr_b,
  input  logic [WIDTH-1:0]      i_din_b,
  output logic [WIDTH-1:0]      o_dout_b,
  output logic                  o_valid_b,
  output logic                  o_collision
);
  localparam int WP_W = ADDR_WIDTH + NB + WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  function automatic logic [WIDTH-1:0] apply_lanes(input logic [WIDTH-1:0] base,
                                                   input logic [NB-1:0]    we,
                                                   input logic [WIDTH-1:0] din);
    logic [WIDTH-1:0] w;
    w = base;
    for (int l = 0; l < NB; l++)
      if (we[l]) w[l*BYTE_W +: BYTE_W] = din[l*BYTE_W +: BYTE_W];
    return w;
  endfunction

  // The losing port is applied first so the winner's enabled lanes overwrite it.
  function automatic logic [WIDTH-1:0] merge_word(input logic [WIDTH-1:0] base,
                                                  input logic hit_a, input logic [NB-1:0] we_a,
                                                  input logic [WIDTH-1:0] din_a,
                                                  input logic hit_b, input logic [NB-1:0] we_b,
                                                  input logic [WIDTH-1:0] din_b);
    logic [WIDTH-1:0] w;
    w = base;
    if (WW_PRIORITY == 0) begin
      if (hit_b) w = apply_lanes(w, we_b, din_b);
      if (hit_a) w = apply_lanes(w, we_a, din_a);
    end else begin
      if (hit_a) w = apply_lanes(w, we_a, din_a);
      if (hit_b) w = apply_lanes(w, we_b, din_b);
    end
    return w;
  endfunction

  // Write pipelines: {addr, we, data} emerge on the commit edge.
  logic                  cv_a, cv_b;
  logic [WP_W-1:0]       cd_a, cd_b;
  logic [ADDR_WIDTH-1:0] c_addr_a, c_addr_b;
  logic [NB-1:0]         c_we_a, c_we_b;
  logic [WIDTH-1:0]      c_din_a, c_din_b;
  logic                  commit_a, commit_b;

  dpm_pipe #(.W(WP_W), .STAGES(WRITE_LATENCY_A - 1)) u_wp_a (
    .clk(i_clk), .rst(i_rst), .in_valid(i_en_a && (|i_we_a)),
    .in_data({i_addr_a, i_we_a, i_din_a}), .out_valid(cv_a), .out_data(cd_a)
  );

  dpm_pipe #(.W(WP_W), .STAGES(WRITE_LATENCY_B - 1)) u_wp_b (
    .clk(i_clk), .rst(i_rst), .in_valid(i_en_b && (|i_we_b)),
    .in_data({i_addr_b, i_we_b, i_din_b}), .out_valid(cv_b), .out_data(cd_b)
  );

  assign {c_addr_a, c_we_a, c_din_a} = cd_a;
  assign {c_addr_b, c_we_b, c_din_b} = cd_b;
  assign commit_a = cv_a && in_range(c_addr_a);
  assign commit_b = cv_b && in_range(c_addr_b);

  logic [WIDTH-1:0] new_ca, new_cb, samp_a, samp_b, raw_a, raw_b;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    new_ca = '0;
    new_cb = '0;
    raw_a  = '0;
    raw_b  = '0;
    if (in_range(c_addr_a))
      new_ca = merge_word(mem[c_addr_a], commit_a, c_we_a, c_din_a,
                          commit_b && (c_addr_b == c_addr_a), c_we_b, c_din_b);
    if (in_range(c_addr_b))
      new_cb = merge_word(mem[c_addr_b], commit_a && (c_addr_a == c_addr_b), c_we_a, c_din_a,
                          commit_b, c_we_b, c_din_b);
    if (in_range(i_addr_a)) raw_a = mem[i_addr_a];
    if (in_range(i_addr_b)) raw_b = mem[i_addr_b];
    samp_a = raw_a;
    samp_b = raw_b;
    if (RDW_MODE == 1) begin
      samp_a = merge_word(raw_a, commit_a && (c_addr_a == i_addr_a), c_we_a, c_din_a,
                          commit_b && (c_addr_b == i_addr_a), c_we_b, c_din_b);
      samp_b = merge_word(raw_b, commit_a && (c_addr_a == i_addr_b), c_we_a, c_din_a,
                          commit_b && (c_addr_b == i_addr_b), c_we_b, c_din_b);
    end
  end

  // NOTE: the array has no reset; committed contents survive a reset pulse.
  always_ff @(posedge i_clk) begin
    if (commit_a) mem[c_addr_a] <= new_ca;
    if (commit_b) mem[c_addr_b] <= new_cb;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_collision <= 1'b0;
    else       o_collision <= commit_a && commit_b && (c_addr_a == c_addr_b);
  end

  // Read pipelines: first stage samples the array on the request edge.
  dpm_pipe #(.W(WIDTH), .STAGES(READ_LATENCY_A)) u_rp_a (
    .clk(i_clk), .rst(i_rst), .in_valid(i_en_a && !(|i_we_a)),
    .in_data(samp_a), .out_valid(o_valid_a), .out_data(o_dout_a)
  );

  dpm_pipe #(.W(WIDTH), .STAGES(READ_LATENCY_B)) u_rp_b (
    .clk(i_clk), .rst(i_rst), .in_valid(i_en_b && !(|i_we_b)),
    .in_data(samp_b), .out_valid(o_valid_b), .out_data(o_dout_b)
  );
endmodule

// File: tb/tb_dual_port_memory_pipelined.sv
// Directed bench: dut0 is the 8-bit default build, dut1 is 16-bit with WRITE_FIRST and port-B priority.
// Both see the same stimulus; dut0 takes the low byte and low write-enable bit.
module tb_dual_port_memory_pipelined;
  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, en_b;
  logic [1:0]  we_a, we_b;
  logic [2:0]  addr_a, addr_b;
  logic [15:0] din_a, din_b;

  logic [7:0]  dout0_a, dout0_b;
  logic        valid0_a, valid0_b, coll0;
  logic [15:0] dout1_a, dout1_b;
  logic        valid1_a, valid1_b, coll1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dual_port_memory_pipelined #(.WIDTH(8)) dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_en_a(en_a), .i_we_a(we_a[0:0]), .i_addr_a(addr_a), .i_din_a(din_a[7:0]),
    .o_dout_a(dout0_a), .o_valid_a(valid0_a),
    .i_en_b(en_b), .i_we_b(we_b[0:0]), .i_addr_b(addr_b), .i_din_b(din_b[7:0]),
    .o_dout_b(dout0_b), .o_valid_b(valid0_b),
    .o_collision(coll0)
  );

  dual_port_memory_pipelined #(.WIDTH(16), .RDW_MODE(1), .WW_PRIORITY(1)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_en_a(en_a), .i_we_a(we_a), .i_addr_a(addr_a), .i_din_a(din_a),
    .o_dout_a(dout1_a), .o_valid_a(valid1_a),
    .i_en_b(en_b), .i_we_b(we_b), .i_addr_b(addr_b), .i_din_b(din_b),
    .o_dout_b(dout1_b), .o_valid_b(valid1_b),
    .o_collision(coll1)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    en_a = 0; we_a = '0; addr_a = '0; din_a = '0;
    en_b = 0; we_b = '0; addr_b = '0; din_b = '0;
  endtask

  task automatic wr_a(input logic [2:0] a, input logic [15:0] d, input logic [1:0] we);
    en_a = 1; we_a = we; addr_a = a; din_a = d;
  endtask

  task automatic wr_b(input logic [2:0] a, input logic [15:0] d, input logic [1:0] we);
    en_b = 1; we_b = we; addr_b = a; din_b = d;
  endtask

  task automatic rd_a(input logic [2:0] a);
    en_a = 1; we_a = '0; addr_a = a; din_a = '0;
  endtask

  task automatic rd_b(input logic [2:0] a);
    en_b = 1; we_b = '0; addr_b = a; din_b = '0;
  endtask

  // Applies the currently driven request on the next edge, then clears it.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_dout0_a", 16'(dout0_a), 16'h0);
    check("rst_valid0_a", 16'(valid0_a), 16'h0);
    check("rst_dout1_b", dout1_b, 16'h0);
    check("rst_valid1_b", 16'(valid1_b), 16'h0);
    check("rst_coll0", 16'(coll0), 16'h0);
    check("rst_coll1", 16'(coll1), 16'h0);

    // Preload: addr0..4 = 10..14, addr5..7 = 0.
    for (int i = 0; i < 4; i++) begin
      wr_a(3'(i), 16'(10 + i), 2'b11);
      wr_b(3'(i + 4), (i == 0) ? 16'd14 : 16'd0, 2'b11);
      step();
    end
    repeat (4) step();

    // Back-to-back reads on A: valid for five consecutive cycles, data in order.
    for (int t = 0; t < 10; t++) begin
      if (t < 5) rd_a(3'(t));
      step();
      check("burst_valid0", 16'(valid0_a), 16'((t >= 4) && (t <= 8)));
      check("burst_valid1", 16'(valid1_a), 16'((t >= 4) && (t <= 8)));
      if (t >= 4 && t <= 8) begin
        check("burst_data0", 16'(dout0_a), 16'(10 + t - 4));
        check("burst_data1", dout1_a, 16'(10 + t - 4));
      end
    end
    check("burst_hold0", 16'(dout0_a), 16'd14);

    // Write 12 to addr0, read it after the commit edge: one-cycle valid.
    for (int t = 0; t < 10; t++) begin
      if (t == 0) wr_a(3'd0, 16'h000C, 2'b11);
      if (t == 4) rd_a(3'd0);
      step();
      check("wr_rd_valid0", 16'(valid0_a), 16'(t == 8));
      if (t == 8) begin
        check("wr_rd_data0", 16'(dout0_a), 16'h000C);
        check("wr_rd_data1", dout1_a, 16'h000C);
      end
    end

    // Cross-port read on the commit edge: old word (dut0) vs new word (dut1).
    for (int t = 0; t < 10; t++) begin
      if (t == 0) wr_b(3'd2, 16'h0009, 2'b11);
      if (t == 3 || t == 4) rd_a(3'd2);
      step();
      if (t == 7) begin
        check("rdw_valid0", 16'(valid0_a), 16'h1);
        check("rdw_read_first", 16'(dout0_a), 16'h000C);
        check("rdw_write_first", dout1_a, 16'h0009);
      end
      if (t == 8) begin
        check("rdw_after0", 16'(dout0_a), 16'h0009);
        check("rdw_after1", dout1_a, 16'h0009);
      end
    end

    // Same-address write collision, full words.
    for (int t = 0; t < 10; t++) begin
      if (t == 0) begin
        wr_a(3'd3, 16'h00AA, 2'b11);
        wr_b(3'd3, 16'h0055, 2'b11);
      end
      if (t == 4) rd_a(3'd3);
      step();
      check("ww_coll0", 16'(coll0), 16'(t == 3));
      check("ww_coll1", 16'(coll1), 16'(t == 3));
      if (t == 8) begin
        check("ww_a_wins", 16'(dout0_a), 16'h00AA);
        check("ww_b_wins", dout1_a, 16'h0055);
      end
    end

    // Per-lane collision on dut1; on dut0 port A is a read (low enable bit clear).
    for (int t = 0; t < 10; t++) begin
      if (t == 0) begin
        wr_a(3'd5, 16'h1122, 2'b10);
        wr_b(3'd5, 16'h3344, 2'b01);
      end
      if (t == 4) rd_b(3'd5);
      step();
      check("lane_coll0", 16'(coll0), 16'h0);
      check("lane_coll1", 16'(coll1), 16'(t == 3));
      if (t == 4) begin
        check("lane_rd_valid0", 16'(valid0_a), 16'h1);
        check("lane_rd_old0", 16'(dout0_a), 16'h0);
        check("lane_rd_valid1", 16'(valid1_a), 16'h0);
      end
      if (t == 8) begin
        check("lane_data0", 16'(dout0_b), 16'h0044);
        check("lane_merge1", dout1_b, 16'h1144);
      end
    end

    // Byte-enable partial overwrite.
    for (int t = 0; t < 10; t++) begin
      if (t == 0) wr_a(3'd1, 16'h1234, 2'b11);
      if (t == 1) wr_a(3'd1, 16'hABCD, 2'b01);
      if (t == 5) rd_b(3'd1);
      step();
      check("be_valid1", 16'(valid1_b), 16'(t == 9));
      if (t == 9) begin
        check("be_data0", 16'(dout0_b), 16'h00CD);
        check("be_data1", dout1_b, 16'h12CD);
      end
    end

    // Reset with a write and a read in flight: both discarded, array kept.
    wr_a(3'd6, 16'h004D, 2'b11);
    rd_b(3'd1);
    step();
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_dout0_b", 16'(dout0_b), 16'h0);
    check("mid_rst_dout1_b", dout1_b, 16'h0);
    check("mid_rst_dout1_a", dout1_a, 16'h0);
    check("mid_rst_valid0_b", 16'(valid0_b), 16'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (t == 0) rd_a(3'd6);
      if (t == 1) rd_b(3'd1);
      step();
      check("post_rst_valid0_a", 16'(valid0_a), 16'(t == 4));
      check("post_rst_valid0_b", 16'(valid0_b), 16'(t == 5));
      if (t == 4) begin
        check("post_rst_addr6_0", 16'(dout0_a), 16'h0);
        check("post_rst_addr6_1", dout1_a, 16'h0);
      end
      if (t == 5) begin
        check("post_rst_addr1_0", 16'(dout0_b), 16'h00CD);
        check("post_rst_addr1_1", dout1_b, 16'h12CD);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
